// File: rtl/dmem_pkg.sv
// Shared types, funct3 encodings and request helpers for the MEM-stage data-memory access unit.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [3:0] be_t;

    // Unsigned sizes exist only for loads; alignment is checked against the access size.
    function automatic logic req_legal(input logic is_store, input logic [2:0] f3, input logic [1:0] lane);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !is_store;
            F3_H:    ok = !lane[0];
            F3_HU:   ok = !is_store && !lane[0];
            F3_W:    ok = (lane == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic be_t store_be(input logic [2:0] f3, input logic [1:0] lane);
        be_t be;
        case (f3)
            F3_B:    be = be_t'(4'b0001 << lane);
            F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data alignment: picks the addressed byte/half of the read word and sign/zero-extends it.
module dmem_load_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_lane,
    input  logic [2:0]        i_funct3,
    output logic [DATA_W-1:0] o_ld_data
);

    logic [DATA_W-1:0] w_shift;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    // Lane select followed by extension according to the access size.
    always_comb begin
        w_shift = i_rdata >> {i_lane, 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_ld_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data = {{(DATA_W-8){1'b0}}, w_byte};
            F3_H:    o_ld_data = {{(DATA_W-16){w_half[15]}}, w_half};
            F3_HU:   o_ld_data = {{(DATA_W-16){1'b0}}, w_half};
            F3_W:    o_ld_data = i_rdata;
            default: o_ld_data = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: req/ack handshake, byte lanes, load alignment and pipeline stall.
// Optional watchdog on outstanding accesses is enabled with the DMEM_TIMEOUT_EN macro.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int TIMEOUT_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  stall,
    output logic                  ld_valid,
    output logic [DATA_W-1:0]     ld_data,
    output logic                  access_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DM_ADDRESS-3:0] mem_addr,
    output be_t                   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    dmem_state_e       r_state;
    logic [1:0]        r_lane;
    logic [2:0]        r_funct3;
    logic              w_legal;
    logic              w_accept;
    logic              w_reject;
    logic              w_timeout;
    logic              w_tmo_fire;
    logic [DATA_W-1:0] w_st_wdata;
    logic [DATA_W-1:0] w_ld_aligned;

    dmem_load_align #(.DATA_W(DATA_W)) u_align (
        .i_rdata   (mem_rdata),
        .i_lane    (r_lane),
        .i_funct3  (r_funct3),
        .o_ld_data (w_ld_aligned)
    );

`ifdef DMEM_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);
    logic [TIMEOUT_W-1:0] r_wd;

    // Counts REQ cycles; the cycle seen with r_wd at WD_LAST is the last one allowed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd <= {TIMEOUT_W{1'b0}};
        end else if ((r_state == REQ) && !mem_ack && (r_wd != WD_LAST)) begin
            r_wd <= r_wd + TIMEOUT_W'(1);
        end else begin
            r_wd <= {TIMEOUT_W{1'b0}};
        end
    end

    assign w_timeout = (r_state == REQ) && (r_wd == WD_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Request decode, store lane replication and the combinational pipeline controls.
    always_comb begin
        w_legal    = req_legal(req_wr, req_funct3, req_addr[1:0]);
        w_accept   = (r_state == IDLE) && (req_rd || req_wr) && w_legal;
        w_reject   = (r_state == IDLE) && (req_rd || req_wr) && !w_legal;
        w_tmo_fire = w_timeout && !mem_ack;
        case (req_funct3)
            F3_B:    w_st_wdata = {4{req_wdata[7:0]}};
            F3_H:    w_st_wdata = {2{req_wdata[15:0]}};
            default: w_st_wdata = req_wdata;
        endcase
        if (reset) begin
            stall      = w_accept || ((r_state == REQ) && !w_tmo_fire);
            access_err = w_reject || w_tmo_fire;
        end else begin
            stall      = 1'b0;
            access_err = 1'b0;
        end
    end

    // Access FSM with request capture; load results are registered on mem_ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_lane    <= 2'b00;
            r_funct3  <= 3'b000;
            ld_valid  <= 1'b0;
            ld_data   <= {DATA_W{1'b0}};
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {(DM_ADDRESS-2){1'b0}};
            mem_be    <= 4'b0000;
            mem_wdata <= {DATA_W{1'b0}};
        end else begin
            ld_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state   <= REQ;
                        r_lane    <= req_addr[1:0];
                        r_funct3  <= req_funct3;
                        mem_req   <= 1'b1;
                        mem_we    <= req_wr;
                        mem_addr  <= req_addr[DM_ADDRESS-1:2];
                        mem_be    <= req_wr ? store_be(req_funct3, req_addr[1:0]) : 4'b1111;
                        mem_wdata <= w_st_wdata;
                    end else if (w_reject) begin
                        ld_data <= {DATA_W{1'b0}};
                    end else begin
                        r_state <= IDLE;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        r_state  <= DONE;
                        mem_req  <= 1'b0;
                        ld_valid <= !mem_we;
                        if (!mem_we) begin
                            ld_data <= w_ld_aligned;
                        end else begin
                            ld_data <= ld_data;
                        end
                    end else if (w_tmo_fire) begin
                        r_state <= IDLE;
                        mem_req <= 1'b0;
                        ld_data <= {DATA_W{1'b0}};
                    end else begin
                        r_state <= REQ;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
